// File: rtl/cbc_dec_xor.sv
// CBC-mode decryption back end: XORs the block-cipher inverse output with the
// chaining value and streams the 128-bit plaintext out as four 32-bit words.
module cbc_dec_xor #(
  parameter int OUT_MSB_FIRST = 1
) (
  input  logic         CLK,
  input  logic         RSTB,
  input  logic         iv_valid,
  input  logic [127:0] iv_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ct,
  input  logic [127:0] in_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         chain_ok
);

  typedef enum logic [1:0] {
    NOIV = 2'd0,
    IDLE = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] plain_q, plain_d;
  logic [1:0]   cnt_q,   cnt_d;

  // Word idx of the block in output order; idx 0 goes out first.
  function automatic logic [31:0] sel_word(input logic [127:0] blk,
                                           input logic [1:0]   idx);
    logic [1:0] slot;
    slot = (OUT_MSB_FIRST != 0) ? ~idx : idx;
    case (slot)
      2'd0:    sel_word = blk[31:0];
      2'd1:    sel_word = blk[63:32];
      2'd2:    sel_word = blk[95:64];
      default: sel_word = blk[127:96];
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= NOIV;
      chain_q <= '0;
      plain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      plain_q <= plain_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an IV load in IDLE takes priority over a block accept
  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    plain_d = plain_q;
    cnt_d   = cnt_q;
    case (state_q)
      NOIV: begin
        if (iv_valid) begin
          chain_d = iv_data;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (iv_valid) begin
          chain_d = iv_data;
        end else if (in_valid) begin
          plain_d = in_dec ^ chain_q;
          chain_d = in_ct;
          cnt_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = NOIV;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == IDLE) && !iv_valid;
    out_valid = (state_q == SEND);
    out_last  = (state_q == SEND) && (cnt_q == 2'd3);
    chain_ok  = (state_q == IDLE) || (state_q == SEND);
    out_data  = sel_word(plain_q, cnt_q);
  end

endmodule

// File: tb/tb_cbc_dec_xor.sv
// Directed bench for cbc_dec_xor: known-answer CBC vectors, IV priority,
// output back-pressure and reset in the middle of a block.
module tb_cbc_dec_xor;

  logic         CLK = 1'b0;
  logic         RSTB;
  logic         iv_valid;
  logic [127:0] iv_data;
  logic         in_valid;
  logic [127:0] in_ct;
  logic [127:0] in_dec;
  logic         out_ready;

  logic         in_ready,  in_ready_l;
  logic         out_valid, out_valid_l;
  logic [31:0]  out_data,  out_data_l;
  logic         out_last,  out_last_l;
  logic         chain_ok,  chain_ok_l;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  cbc_dec_xor #(.OUT_MSB_FIRST(1)) dut (
    .CLK(CLK), .RSTB(RSTB), .iv_valid(iv_valid), .iv_data(iv_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_ct(in_ct), .in_dec(in_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .chain_ok(chain_ok)
  );

  cbc_dec_xor #(.OUT_MSB_FIRST(0)) dut_lsb (
    .CLK(CLK), .RSTB(RSTB), .iv_valid(iv_valid), .iv_data(iv_data),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_ct(in_ct), .in_dec(in_dec),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
    .out_last(out_last_l), .chain_ok(chain_ok_l)
  );

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTB = 1'b0; iv_valid = 1'b0; iv_data = '0; in_valid = 1'b0;
    in_ct = '0; in_dec = '0; out_ready = 1'b1;
    cyc(); cyc();
    #2;
    total_cnt++;
    if ({in_ready, out_valid, out_last, chain_ok, out_data} !== 36'd0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b ok=%b data=%h, want all 0",
               in_ready, out_valid, out_last, chain_ok, out_data);
    else pass_cnt++;
    cyc();
    RSTB = 1'b1;
  endtask

  task automatic test_noiv_hold();
    in_valid = 1'b1;
    in_ct    = {4{32'h12345678}};
    in_dec   = {4{32'h9abcdef0}};
    for (int c = 0; c < 10; c++) begin
      cyc();
      #2;
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || chain_ok !== 1'b0)
        $display("FAIL noiv_hold_c%0d: got rdy=%b vld=%b ok=%b, want 0 0 0",
                 c, in_ready, out_valid, chain_ok);
      else pass_cnt++;
    end
    cyc();
    in_valid = 1'b0;
    iv_valid = 1'b1;
    iv_data  = 128'h000102030405060708090a0b0c0d0e0f;
    cyc();
    iv_valid = 1'b0;
    #2;
    total_cnt++;
    if (chain_ok !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL iv_load: got chain_ok=%b in_ready=%b, want 1 1", chain_ok, in_ready);
    else pass_cnt++;
  endtask

  // Two chained blocks of the CBC known-answer test with out_ready held high.
  task automatic test_cbc_chain();
    logic [127:0] cts  [2];
    logic [127:0] decs [2];
    logic [31:0]  exp  [2][4];
    cts[0]  = 128'h7649abac8119b246cee98e9b12e9197d;
    decs[0] = 128'h6bc0bce12a459991e134741a7f9e1925;
    cts[1]  = 128'h5086cb9b507219ee95db113a917678b2;
    decs[1] = 128'h0;
    exp[0][0] = 32'h6bc1bee2; exp[0][1] = 32'h2e409f96;
    exp[0][2] = 32'he93d7e11; exp[0][3] = 32'h7393172a;
    exp[1][0] = 32'h7649abac; exp[1][1] = 32'h8119b246;
    exp[1][2] = 32'hcee98e9b; exp[1][3] = 32'h12e9197d;
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_ct    = cts[b];
      in_dec   = decs[b];
      #2;
      total_cnt++;
      if (in_ready !== 1'b1)
        $display("FAIL blk%0d_ready: got in_ready=%b, want 1", b, in_ready);
      else pass_cnt++;
      cyc();
      in_valid = 1'b0;
      for (int w = 0; w < 4; w++) begin
        #2;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp[b][w] || out_last !== (w == 3) ||
            in_ready !== 1'b0)
          $display("FAIL blk%0d_w%0d: got vld=%b data=%h last=%b rdy=%b, want 1 %h %b 0",
                   b, w, out_valid, out_data, out_last, in_ready, exp[b][w], (w == 3));
        else pass_cnt++;
        total_cnt++;
        if (out_data_l !== exp[b][3-w] || out_last_l !== (w == 3))
          $display("FAIL blk%0d_lsb_w%0d: got data=%h last=%b, want %h %b",
                   b, w, out_data_l, out_last_l, exp[b][3-w], (w == 3));
        else pass_cnt++;
        cyc();
      end
      #2;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL blk%0d_done: got vld=%b rdy=%b, want 0 1", b, out_valid, in_ready);
      else pass_cnt++;
      cyc();
    end
  endtask

  task automatic test_iv_priority();
    logic [31:0] exp [4];
    exp[0] = 32'h11111111; exp[1] = 32'h22222222;
    exp[2] = 32'h33333333; exp[3] = 32'h44444444;
    iv_valid = 1'b1;
    iv_data  = 128'h11111111222222223333333344444444;
    in_valid = 1'b1;
    in_ct    = 128'h0123456789abcdeffedcba9876543210;
    in_dec   = 128'h0;
    #2;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL iv_prio_ready: got in_ready=%b, want 0", in_ready);
    else pass_cnt++;
    cyc();
    iv_valid = 1'b0;
    #2;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL iv_prio_not_taken: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    else pass_cnt++;
    cyc();
    in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #2;
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp[w])
        $display("FAIL iv_prio_w%0d: got vld=%b data=%h, want 1 %h",
                 w, out_valid, out_data, exp[w]);
      else pass_cnt++;
      cyc();
    end
  endtask

  // out_ready pattern 1,0,0 repeating; iv_valid held high must be ignored.
  task automatic test_stall();
    logic [31:0] exp [4];
    logic        pat [3];
    int          n;
    int          c;
    exp[0] = 32'h01234567; exp[1] = 32'h89abcdef;
    exp[2] = 32'hfedcba98; exp[3] = 32'h76543210;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    in_valid = 1'b1;
    in_ct    = 128'hcafef00dcafef00dcafef00dcafef00d;
    in_dec   = 128'h0;
    cyc();
    in_valid = 1'b0;
    iv_valid = 1'b1;
    iv_data  = 128'hffffffffffffffffffffffffffffffff;
    n = 0;
    c = 0;
    while (n < 4 && c < 30) begin
      out_ready = pat[c % 3];
      #2;
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp[n] || out_last !== (n == 3) ||
          in_ready !== 1'b0)
        $display("FAIL stall_c%0d: got vld=%b data=%h last=%b rdy=%b, want 1 %h %b 0",
                 c, out_valid, out_data, out_last, in_ready, exp[n], (n == 3));
      else pass_cnt++;
      if (out_valid === 1'b1 && out_ready) n++;
      c++;
      cyc();
    end
    iv_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    total_cnt++;
    if (n !== 4 || out_valid !== 1'b0)
      $display("FAIL stall_count: got transfers=%0d vld=%b, want 4 0", n, out_valid);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_reset_mid();
    // Chain is still cafef00d... because the IV offered during SEND was ignored.
    in_valid = 1'b1;
    in_ct    = 128'h0;
    in_dec   = 128'h0;
    cyc();
    in_valid = 1'b0;
    #2;
    total_cnt++;
    if (out_data !== 32'hcafef00d)
      $display("FAIL iv_ignored: got data=%h, want cafef00d", out_data);
    else pass_cnt++;
    cyc(); cyc();
    RSTB = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, out_last, chain_ok, out_data} !== 36'd0)
      $display("FAIL midreset_outputs: got rdy=%b vld=%b last=%b ok=%b data=%h, want all 0",
               in_ready, out_valid, out_last, chain_ok, out_data);
    else pass_cnt++;
    cyc();
    RSTB     = 1'b1;
    in_valid = 1'b1;
    in_dec   = {4{32'h55555555}};
    for (int c = 0; c < 3; c++) begin
      cyc();
      #2;
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL midreset_noiv_c%0d: got rdy=%b vld=%b, want 0 0", c, in_ready, out_valid);
      else pass_cnt++;
    end
    cyc();
    in_valid = 1'b0;
    iv_valid = 1'b1;
    iv_data  = {4{32'haaaaaaaa}};
    cyc();
    iv_valid = 1'b0;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #2;
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'hffffffff)
        $display("FAIL midreset_blk_w%0d: got vld=%b data=%h, want 1 ffffffff",
                 w, out_valid, out_data);
      else pass_cnt++;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_noiv_hold();
    test_cbc_chain();
    test_iv_priority();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cbc_dec_xor.md
CBC_DEC_XOR -- requirements
Module: cbc_dec_xor

Interface
REQ-001 SHALL have parameter OUT_MSB_FIRST, default 1; 1 = word 0 is bits 127:96, 0 = word 0 is bits 31:0.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port RSTB  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iv_valid  input  1  load a new chaining value this cycle.
REQ-005 SHALL have port iv_data  input  128  initialisation vector.
REQ-006 SHALL have port in_valid  input  1  ciphertext block plus its block-decrypt result offered.
REQ-007 SHALL have port in_ready  output  1  block accepted when in_valid and in_ready are both 1.
REQ-008 SHALL have port in_ct  input  128  ciphertext block C(i).
REQ-009 SHALL have port in_dec  input  128  block-cipher inverse output D(C(i)).
REQ-010 SHALL have port out_valid  output  1  out_data holds a plaintext word.
REQ-011 SHALL have port out_ready  input  1  sink takes the word when out_valid and out_ready are both 1.
REQ-012 SHALL have port out_data  output  32  plaintext word.
REQ-013 SHALL have port out_last  output  1  current word is word 3 of the block.
REQ-014 SHALL have port chain_ok  output  1  a chaining value is loaded.

Function
REQ-015 SHALL implement states NOIV, IDLE and SEND, a 128-bit chain register, a 128-bit plain register and a 2-bit word counter cnt.
REQ-016 NOIV: in_ready=0, out_valid=0, chain_ok=0; iv_valid=1 -> chain<=iv_data, go to IDLE.
REQ-017 IDLE: chain_ok=1; iv_valid=1 -> chain<=iv_data, stay in IDLE.
REQ-018 IDLE: in_ready SHALL be combinational (state==IDLE && !iv_valid); IV load wins when iv_valid and in_valid are both high.
REQ-019 Accept in IDLE: plain<=in_dec XOR chain, chain<=in_ct, cnt<=0, go to SEND.
REQ-020 SEND: out_valid=1 and in_ready=0; out_data = word cnt of plain, ordered per OUT_MSB_FIRST; out_last=(cnt==3).
REQ-021 SEND: out_valid&&out_ready with cnt<3 -> cnt+1; with cnt==3 -> cnt<=0, go to IDLE.
REQ-022 SEND: out_valid=1 and out_ready=0 -> out_data, out_last and cnt SHALL hold unchanged.
REQ-023 iv_valid SHALL be ignored in SEND; the chain value is not changed and the IV is not deferred.
REQ-024 Latency: block accepted at edge k -> out_valid=1 after edge k; with out_ready held at 1, the last word transfers at edge k+4 and in_ready=1 again after edge k+4.
REQ-025 Throughput: at most one block per 5 cycles; no overlap of accept and output.
REQ-026 The XOR SHALL be bitwise over 128 bits, with no carry and no truncation.
REQ-027 Chaining SHALL persist across blocks until a new IV is loaded or reset is asserted.

Reset
REQ-028 RSTB=0 SHALL immediately force: state=NOIV, chain=0, plain=0, cnt=0, in_ready=0, out_valid=0, out_last=0, out_data=0, chain_ok=0.
REQ-029 Reset during SEND SHALL drop the partial block with no further out_valid; an IV is required before the next accept.
REQ-030 After RSTB deasserts, the block SHALL stay in NOIV until the first iv_valid, regardless of in_valid.

Verification
REQ-031 Load IV 000102030405060708090a0b0c0d0e0f; in_ct=7649abac8119b246cee98e9b12e9197d, in_dec=6bc0bce12a459991e134741a7f9e1925, out_ready=1 -> words 6bc1bee2, 2e409f96, e93d7e11, 7393172a; out_last on the 4th word.
REQ-032 Follow-on block with in_dec=0 -> words 7649abac, 8119b246, cee98e9b, 12e9197d, proving chain=C(1).
REQ-033 After reset with in_valid=1 and no IV -> in_ready stays 0 for 10 cycles; then iv_valid pulse -> chain_ok=1 next cycle.
REQ-034 iv_valid and in_valid high together in IDLE -> IV loaded, block not accepted; block accepted the next cycle using the new IV.
REQ-035 out_ready toggles 1,0,0,1,... in SEND -> word held stable while stalled; exactly 4 transfers; no word lost or duplicated.
REQ-036 RSTB pulsed low after 2nd word of a block -> outputs 0 at once; next block is not accepted until a new IV is loaded.
